// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Control FSM for a bit-serial adder. It accepts an operand pair,
//            drives an external shift-register/full-adder datapath for WIDTH
//            cycles, assembles the LSB-first sum stream and presents the
//            result with a valid/ready handshake.
// Ports    : clk, rst                   - clock, async active-high reset
//            in_valid/in_ready, in_a/in_b - operand request handshake
//            out_valid/out_ready          - result handshake
//            out_sum, out_cout            - assembled sum and final carry
//            busy                         - controller not idle
//            dp_load/dp_data_a/dp_data_b  - parallel load of operand shifters
//            dp_enable, dp_clr            - shift/carry enable, carry clear
//            dp_sum, dp_carry             - datapath full-adder outputs
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8  // operand width and number of shift cycles (2..32)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy,
  output logic             dp_load,
  output logic [WIDTH-1:0] dp_data_a,
  output logic [WIDTH-1:0] dp_data_b,
  output logic             dp_enable,
  output logic             dp_clr,
  input  logic             dp_sum,
  input  logic             dp_carry
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_SHIFT = 2'd2;
  localparam logic [1:0] C_DONE  = 2'd3;

  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == C_IDLE) && in_valid;
  assign w_last   = (r_state == C_SHIFT) && (r_cnt == C_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      C_IDLE:  if (in_valid)  w_next = C_LOAD;
      C_LOAD:                 w_next = C_SHIFT;
      C_SHIFT: if (w_last)    w_next = C_DONE;
      C_DONE:  if (out_ready) w_next = C_IDLE;
      default:                w_next = C_IDLE;
    endcase
  end

  // Output decode: everything below depends on the state register only
  // (in_ready additionally masks the reset so it reads 0 during reset).
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    dp_load   = 1'b0;
    dp_clr    = 1'b0;
    dp_enable = 1'b0;
    case (r_state)
      C_IDLE: begin
        in_ready = ~rst;
        busy     = 1'b0;
      end
      C_LOAD: begin
        dp_load = 1'b1;
        dp_clr  = 1'b1;   // clears the datapath carry so nothing leaks across ops
      end
      C_SHIFT: dp_enable = 1'b1;
      C_DONE:  out_valid = 1'b1;
      default: busy      = 1'b1;
    endcase
  end

  // Operand capture, result assembly and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_op_a <= in_a;
        r_op_b <= in_b;
      end
      if (r_state == C_LOAD) begin
        r_cnt <= '0;
      end
      if (r_state == C_SHIFT) begin
        // Sum bits arrive LSB first, so shift them in from the top.
        r_result <= {dp_sum, r_result[WIDTH-1:1]};
        if (w_last) begin
          r_cout <= dp_carry;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + C_ONE;
        end
      end
    end
  end

  assign dp_data_a = r_op_a;
  assign dp_data_b = r_op_b;
  assign out_sum   = r_result;
  assign out_cout  = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Self-checking bench for serial_add_ctrl. Provides a model of the
//            external serial datapath, directed scenarios and a random sweep
//            scored against plain a+b arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
  logic         dp_load;
  logic [W-1:0] dp_data_a;
  logic [W-1:0] dp_data_b;
  logic         dp_enable;
  logic         dp_clr;
  logic         dp_sum;
  logic         dp_carry;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc    = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy),
    .dp_load   (dp_load),
    .dp_data_a (dp_data_a),
    .dp_data_b (dp_data_b),
    .dp_enable (dp_enable),
    .dp_clr    (dp_clr),
    .dp_sum    (dp_sum),
    .dp_carry  (dp_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // External datapath: two operand shift registers, a carry flop and a full adder.
  logic [W-1:0] sh_a = '0;
  logic [W-1:0] sh_b = '0;
  logic         sh_c = 1'b0;

  always @(posedge clk) begin
    if (dp_load) begin
      sh_a <= dp_data_a;
      sh_b <= dp_data_b;
    end else if (dp_enable) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
    end
    if (dp_clr)         sh_c <= 1'b0;
    else if (dp_enable) sh_c <= dp_carry;
  end

  assign dp_sum   = sh_a[0] ^ sh_b[0] ^ sh_c;
  assign dp_carry = (sh_a[0] & sh_b[0]) | (sh_c & (sh_a[0] ^ sh_b[0]));

  // Scoreboard and protocol monitor, sampled on the falling edge.
  logic [W:0]   exp_q[$];
  logic [W:0]   held;
  logic [W-1:0] exp_a, exp_b;
  int           acc_edge = 0;
  int           en_cnt   = 0;
  bit           prev_ov  = 1'b0;
  bit           prev_ordy = 1'b0;
  bit           prev_load = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_ov   = 1'b0;
      prev_ordy = 1'b0;
      prev_load = 1'b0;
      en_cnt    = 0;
    end else begin
      logic [W:0] s;
      check("busy_vs_ready", busy, !in_ready);
      check("strobe_excl", (dp_enable & (dp_load | dp_clr)) | (dp_load ^ dp_clr), 0);
      if (dp_load) begin
        check("load_data", {dp_data_a, dp_data_b}, {exp_a, exp_b});
        check("load_clr", dp_clr, 1);
      end
      if (prev_load) check("load_to_shift", {dp_load, dp_enable}, 2'b01);
      if (dp_enable) en_cnt++;
      if (out_valid && !prev_ov) begin
        check("latency", cyc - acc_edge, W + 1);
        check("enable_cycles", en_cnt, W);
        held = {out_cout, out_sum};
      end
      if (prev_ov && !prev_ordy) check("valid_held", out_valid, 1);
      if (out_valid && prev_ov) check("data_held", {out_cout, out_sum}, held);
      if (out_valid && out_ready) begin
        check("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          s = exp_q.pop_front();
          check("sum", {out_cout, out_sum}, s);
        end
      end
      if (in_valid && in_ready) begin
        s = {1'b0, in_a} + {1'b0, in_b};
        exp_q.push_back(s);
        exp_a    = in_a;
        exp_b    = in_b;
        acc_edge = cyc + 1;
        en_cnt   = 0;
        n_acc++;
      end
      prev_ov   = out_valid;
      prev_ordy = out_ready;
      prev_load = dp_load;
    end
  end

  // Stimulus helpers: all drive at #1 after the rising edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 4 * W) begin
      @(posedge clk); #1;
      n++;
    end
    check("result_wait", out_valid, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"}, {in_ready, out_valid, busy, dp_load, dp_enable, dp_clr, out_cout}, 0);
    check({tag, "_sum"}, out_sum, 0);
    check({tag, "_data"}, {dp_data_a, dp_data_b}, 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    // 5A + 3C
    send(8'h5A, 8'h3C);
    wait_valid();
    check("t_5a3c", {out_cout, out_sum}, 9'h096);
    @(posedge clk); #1;

    // FF + 01 then 00 + 00 back to back: carry must not leak
    send(8'hFF, 8'h01);
    wait_valid();
    check("t_ff01", {out_cout, out_sum}, 9'h100);
    @(posedge clk); #1;
    check("t_b2b_ready", in_ready, 1);
    send(8'h00, 8'h00);
    wait_valid();
    check("t_0000", {out_cout, out_sum}, 9'h000);
    @(posedge clk); #1;

    // Backpressure for 20 cycles with stray in_valid pulses
    out_ready = 1'b0;
    send(8'hC3, 8'h7E);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      in_valid = $urandom_range(0, 1);
      in_a = W'($urandom);
      in_b = W'($urandom);
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_data", {out_cout, out_sum}, 9'h141);
      check("bp_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {out_valid, in_ready}, 2'b01);

    // Reset in the middle of SHIFT
    send(8'hAA, 8'h55);
    repeat (5) @(posedge clk);
    #1;
    check("pre_abort_shift", dp_enable, 1);
    rst = 1'b1;
    #1;
    check_reset_vals("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ready_after_abort", in_ready, 1);
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      check("no_out_after_abort", out_valid, 0);
    end
    send(8'h12, 8'h34);
    wait_valid();
    check("t_1234", {out_cout, out_sum}, 9'h046);
    @(posedge clk); #1;

    // Random sweep
    for (int i = 0; i < 25000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_a      = pick();
      in_b      = pick();
      out_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3 * W) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", {out_valid, busy}, 0);
    check("sweep_ops", n_acc > 1000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
